des_out_buffer: RTL

- Sits directly downstream of the 18-cycle fully pipelined DES core.
- The core has no backpressure, so this block provides a credit-gated result buffer:
  - counts issued blocks and tells the upstream issuer when a slot is guaranteed;
  - stores completed 64-bit results in a FIFO;
  - serialises each result as 8 bytes over a ready/valid byte stream, MSB byte first.

---
 rtl/des_pkg.sv | 28 ++
 rtl/des_fifo.sv | 87 ++++++++
 rtl/des_out_buffer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared constants and helpers for the DES datapath and its output buffer.
//   DES_BLOCK_W  : width of one DES block in bits
//   DES_BYTES    : bytes per block on the byte stream
//   DES_PIPE_LAT : latency of the fully pipelined DES core (cycles)
// -----------------------------------------------------------------------------
package des_pkg;

  localparam int DES_BLOCK_W  = 64;
  localparam int DES_BYTES    = 8;
  localparam int DES_PIPE_LAT = 18;

  // Per-head view of the output buffer: nothing to send, or a block at the head.
  typedef enum logic {
    OB_IDLE = 1'b0,
    OB_SEND = 1'b1
  } ob_state_e;

  // Byte idx of a block, idx 0 being the most significant byte.
  function automatic logic [7:0] block_byte(input logic [DES_BLOCK_W-1:0] blk,
                                            input logic [2:0] idx);
    logic [5:0] lsb;
    lsb = {3'd7 - idx, 3'b000};
    return blk[lsb +: 8];
  endfunction

endpackage

// File: rtl/des_fifo.sv
// -----------------------------------------------------------------------------
// des_fifo
// Generic synchronous FIFO with a combinational head.
//   clk_i      : clock, rising edge
//   reset_i    : asynchronous active-low reset
//   wr_en_i    : write wr_data_i (accepted when not full, or full with a read)
//   wr_data_i  : write data
//   rd_en_i    : pop the head (ignored when empty)
//   rd_data_o  : current head entry
//   count_o    : number of stored entries
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
// -----------------------------------------------------------------------------
module des_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_rd_s;
  logic             do_wr_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == DEPTH_C);
  assign do_rd_s   = rd_en_i & ~empty_o;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_wr_s   = wr_en_i & (~full_o | do_rd_s);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Next occupancy from the write/read pair.
  always_comb begin
    count_d = count_q;
    case ({do_wr_s, do_rd_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_wr_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_rd_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage array, cleared on reset so no stale block can ever be presented.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_wr_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/des_out_buffer.sv
// -----------------------------------------------------------------------------
// des_out_buffer
// Credit-gated result buffer behind the 18-cycle DES pipeline. Counts blocks in
// flight plus blocks held, stores finished blocks, and streams each block as
// 8 bytes (most significant first) over a ready/valid byte interface.
//   clk_i        : clock, rising edge
//   reset_i      : asynchronous active-low reset (also resets the core)
//   issue_i      : a block entered the core this cycle
//   issue_ok_o   : upstream may issue this cycle (a buffer slot is guaranteed)
//   valid_i      : core output valid; data_i holds a finished block
//   data_i       : finished block, bit 0 is DES bit 1 (MSB)
//   byte_o       : current output byte (0 when nothing is buffered)
//   byte_valid_o : byte_o valid
//   byte_ready_i : sink takes byte_o when high together with byte_valid_o
//   overflow_o   : sticky protocol error (issue without credit, or dropped block)
// -----------------------------------------------------------------------------
module des_out_buffer
  import des_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        issue_i,
  output logic        issue_ok_o,
  input  logic        valid_i,
  input  logic [0:63] data_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic        overflow_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [2:0]    LAST_IDX = 3'(DES_BYTES - 1);

  ob_state_e              state_q;
  logic [2:0]             idx_q;
  logic [2:0]             idx_d;
  logic [CW-1:0]          credits_q;
  logic [CW-1:0]          credits_d;
  logic                   overflow_q;
  logic                   overflow_d;

  logic [DES_BLOCK_W-1:0] wr_data_s;
  logic [DES_BLOCK_W-1:0] head_s;
  logic [CW-1:0]          fifo_count_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   xfer_s;
  logic                   pop_s;
  logic                   pop_dec_s;
  logic                   wr_acc_s;
  logic                   issue_ok_s;
  logic                   issue_acc_s;

  // data_i[0] is the MSB, so a straight packed copy keeps significance.
  assign wr_data_s    = data_i;

  assign byte_valid_o = (state_q == OB_SEND);
  assign xfer_s       = byte_valid_o & ~fifo_empty_s & byte_ready_i;
  assign pop_s        = xfer_s & (idx_q == LAST_IDX);
  assign wr_acc_s     = valid_i & (~fifo_full_s | pop_s);

  // Only the registered counter feeds issue_ok_o, so byte_ready_i never reaches it.
  assign issue_ok_s   = (credits_q < DEPTH_C);
  assign issue_ok_o   = issue_ok_s;
  assign issue_acc_s  = issue_i & issue_ok_s;
  // Guard against an unmatched pop (core output without a counted issue).
  assign pop_dec_s    = pop_s & (credits_q != '0);

  assign overflow_o   = overflow_q;

  des_fifo #(
    .WIDTH (DES_BLOCK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_en_i   (wr_acc_s),
    .wr_data_i (wr_data_s),
    .rd_en_i   (pop_s),
    .rd_data_o (head_s),
    .count_o   (fifo_count_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s)
  );

  // Byte mux: head byte selected by the byte index, zero when idle.
  always_comb begin
    byte_o = 8'h00;
    if (byte_valid_o) begin
      byte_o = block_byte(head_s, idx_q);
    end else begin
      byte_o = 8'h00;
    end
  end

  // Next byte index, credit count and sticky error.
  always_comb begin
    idx_d      = idx_q;
    credits_d  = credits_q;
    overflow_d = overflow_q;

    if (xfer_s) begin
      if (idx_q == LAST_IDX) begin
        idx_d = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      idx_d = idx_q;
    end

    case ({issue_acc_s, pop_dec_s})
      2'b10:   credits_d = credits_q + CW'(1);
      2'b01:   credits_d = credits_q - CW'(1);
      default: credits_d = credits_q;
    endcase

    if ((issue_i & ~issue_ok_s) | (valid_i & ~wr_acc_s)) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Registers for byte index, credits and the error flag.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      idx_q      <= 3'd0;
      credits_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
    end
  end

  // Head state: SEND whenever at least one block is buffered.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= OB_IDLE;
    end else begin
      case (state_q)
        OB_IDLE: begin
          if (wr_acc_s) begin
            state_q <= OB_SEND;
          end else begin
            state_q <= OB_IDLE;
          end
        end
        OB_SEND: begin
          // Last block leaves with nothing arriving behind it.
          if (pop_s && (fifo_count_s == CW'(1)) && !wr_acc_s) begin
            state_q <= OB_IDLE;
          end else begin
            state_q <= OB_SEND;
          end
        end
        default: state_q <= OB_IDLE;
      endcase
    end
  end

endmodule
